kbd_fifo: RTL and testbench

//   Scan-code buffer between the PS/2 receiver (ps2: done/data) and the CPU

---
 rtl/kbd_fifo_if.sv | 15 +
 rtl/kbd_fifo.sv | 80 ++++++++
 tb/tb_kbd_fifo.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/kbd_fifo_if.sv
// kbd_fifo_if: keyboard FIFO bus between the ps2 receiver/CPU port side (master) and the FIFO (slave)
interface kbd_fifo_if #(parameter int DEPTH_LOG2 = 4);
  logic                  kb_done;
  logic [7:0]            kb_data;
  logic                  rd;
  logic                  clr;
  logic [7:0]            dout;
  logic [DEPTH_LOG2:0]   count;
  logic                  empty;
  logic                  full;
  logic                  overflow;
  logic                  irq;
  modport master (output kb_done, kb_data, rd, clr, input dout, count, empty, full, overflow, irq);
  modport slave (input kb_done, kb_data, rd, clr, output dout, count, empty, full, overflow, irq);
endinterface

// File: rtl/kbd_fifo.sv
// kbd_fifo: scan-code FIFO between ps2 and CPU port 0x22; define KBD_BREAK_FOLD_EN to fold F0 break prefixes into bit 7
module kbd_fifo #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic     clock_25,
  input  logic     reset,
  kbd_fifo_if.slave bus
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_COUNT = (DEPTH_LOG2 + 1)'(DEPTH);
  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH_LOG2:0]   count;
  logic [DEPTH_LOG2:0]   count_next;
  logic                  empty;
  logic                  full;
  logic                  overflow;
  logic                  irq;
  logic [7:0]            dout;
  logic [7:0]            dout_next;
  logic [7:0]            wr_byte;
  logic                  wr_req;
  logic                  push;
  logic                  pop;
  logic                  drop;
`ifdef KBD_BREAK_FOLD_EN
  logic fold_pending;
  logic is_break;
  assign is_break = bus.kb_data == 8'hF0;
  assign wr_req   = bus.kb_done & ~is_break;
  assign wr_byte  = fold_pending ? {1'b1, bus.kb_data[6:0]} : bus.kb_data;
  // a break prefix arms the fold; the next real byte disarms it whether kept or dropped
  always_ff @(posedge clock_25 or posedge reset)
    if (reset) fold_pending <= 1'b0;
    else if (bus.kb_done) fold_pending <= is_break;
`else
  assign wr_req  = bus.kb_done;
  assign wr_byte = bus.kb_data;
`endif
  // a pop frees a slot in the same cycle, so a full FIFO still accepts a byte alongside rd
  assign pop  = bus.rd & ~empty;
  assign push = wr_req & (~full | bus.rd);
  assign drop = wr_req & full & ~bus.rd;
  // occupancy update and next head; dout stays 0 for the cycle after a push into an empty FIFO
  always_comb begin
    count_next = (push & ~pop) ? count + 1'b1 : (pop & ~push) ? count - 1'b1 : count;
    dout_next  = (empty || count_next == '0) ? 8'h00 : mem[rd_ptr];
  end
  // storage needs no reset; contents are only observed through rd_ptr within count
  always_ff @(posedge clock_25)
    if (push) mem[wr_ptr] <= wr_byte;
  // pointers, flags and registered head
  always_ff @(posedge clock_25 or posedge reset)
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      empty    <= 1'b1;
      full     <= 1'b0;
      overflow <= 1'b0;
      irq      <= 1'b0;
      dout     <= 8'h00;
    end else begin
      wr_ptr   <= push ? wr_ptr + 1'b1 : wr_ptr;
      rd_ptr   <= pop ? rd_ptr + 1'b1 : rd_ptr;
      count    <= count_next;
      empty    <= count_next == '0;
      full     <= count_next == FULL_COUNT;
      overflow <= drop | (overflow & ~bus.clr);
      irq      <= push;
      dout     <= dout_next;
    end
  assign bus.dout     = dout;
  assign bus.count    = count;
  assign bus.empty    = empty;
  assign bus.full     = full;
  assign bus.overflow = overflow;
  assign bus.irq      = irq;
endmodule

// File: tb/tb_kbd_fifo.sv
// tb_kbd_fifo: randomized scoreboard bench for kbd_fifo against a queue-based reference model
module tb_kbd_fifo;
  localparam int DL = 4;
  localparam int DEPTH = 1 << DL;
`ifdef KBD_BREAK_FOLD_EN
  localparam bit FOLD = 1'b1;
`else
  localparam bit FOLD = 1'b0;
`endif
  typedef struct {
    int         count;
    bit         ovf;
    bit         irq;
    bit         dknown;
    logic [7:0] dout;
  } st_t;
  logic clock_25 = 1'b0;
  logic reset = 1'b1;
  kbd_fifo_if #(.DEPTH_LOG2(DL)) bus ();
  kbd_fifo #(.DEPTH_LOG2(DL)) dut (.clock_25(clock_25), .reset(reset), .bus(bus));
  always #5 clock_25 = ~clock_25;
  int checks = 0;
  int failures = 0;
  logic [7:0] mq[$];
  logic [7:0] exp_q[$];
  st_t st_q[$];
  st_t ms;
  bit pend = 1'b0;
  bit ovf = 1'b0;
  bit last_changed = 1'b0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask
  task automatic reset_checks();
    chk("rst_count", 32'(bus.count), 0);
    chk("rst_empty", 32'(bus.empty), 1);
    chk("rst_full", 32'(bus.full), 0);
    chk("rst_overflow", 32'(bus.overflow), 0);
    chk("rst_irq", 32'(bus.irq), 0);
    chk("rst_dout", 32'(bus.dout), 0);
  endtask
  task automatic step(input bit d, input logic [7:0] data, input bit want, input bit c);
    st_t s;
    bit r, pop, f0, wr, acc, hc;
    logic [7:0] b;
    r = want && !(mq.size() > 0 && last_changed);
    bus.kb_done = d;
    bus.kb_data = data;
    bus.rd = r;
    bus.clr = c;
    pop = r && mq.size() > 0;
    f0 = FOLD && d && data == 8'hF0;
    wr = d && !f0;
    acc = wr && (mq.size() < DEPTH || pop);
    b = (FOLD && pend) ? {1'b1, data[6:0]} : data;
    hc = pop || (acc && mq.size() == 0);
    if (pop) exp_q.push_back(mq.pop_front());
    if (acc) mq.push_back(b);
    if (wr) pend = 1'b0;
    if (f0) pend = 1'b1;
    if (wr && !acc) ovf = 1'b1;
    else if (c) ovf = 1'b0;
    last_changed = hc;
    s.count = mq.size();
    s.ovf = ovf;
    s.irq = acc;
    s.dknown = mq.size() == 0 || !hc;
    s.dout = mq.size() == 0 ? 8'h00 : mq[0];
    @(posedge clock_25);
    st_q.push_back(s);
    #1;
  endtask
  task automatic drain();
    for (int n = 0; n < 200 && mq.size() > 0; n++) begin
      step(1'b0, 8'h00, 1'b1, 1'b0);
      step(1'b0, 8'h00, 1'b0, 1'b0);
    end
  endtask
  always @(negedge clock_25)
    if (!reset) begin
      if (st_q.size() > 0) begin
        ms = st_q.pop_front();
        chk("count", 32'(bus.count), 32'(ms.count));
        chk("empty", 32'(bus.empty), 32'(ms.count == 0));
        chk("full", 32'(bus.full), 32'(ms.count == DEPTH));
        chk("overflow", 32'(bus.overflow), 32'(ms.ovf));
        chk("irq", 32'(bus.irq), 32'(ms.irq));
        if (ms.dknown) chk("dout", 32'(bus.dout), 32'(ms.dout));
      end
      if (bus.rd && !bus.empty) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL pop_unexpected actual=pop_of_%0h required=no_pop", bus.dout);
        end else chk("pop_dout", 32'(bus.dout), 32'(exp_q.pop_front()));
      end
    end
  initial begin
    bus.kb_done = 1'b0;
    bus.kb_data = 8'h00;
    bus.rd = 1'b0;
    bus.clr = 1'b0;
    repeat (3) @(posedge clock_25);
    #1;
    reset_checks();
    reset = 1'b0;
    step(1'b1, 8'h1C, 1'b0, 1'b0);
    repeat (2) step(1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    for (int i = 1; i <= 17; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    drain();
    step(1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 16; i++) step(1'b1, 8'(8'h60 + i), 1'b0, 1'b0);
    repeat (2) step(1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b1, 8'hAA, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    drain();
    for (int i = 0; i < 40; i++) begin
      step(1'b1, 8'(8'h80 + i), 1'b1, 1'b0);
      step(1'b0, 8'h00, 1'b1, 1'b0);
    end
    drain();
    for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h30 + i), 1'b0, 1'b0);
    step(1'b1, 8'hF0, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    @(negedge clock_25);
    #1 reset = 1'b1;
    #1 reset_checks();
    mq.delete();
    pend = 1'b0;
    ovf = 1'b0;
    last_changed = 1'b0;
    @(posedge clock_25);
    #1;
    reset_checks();
    reset = 1'b0;
    step(1'b1, 8'h5A, 1'b0, 1'b0);
    repeat (2) step(1'b0, 8'h00, 1'b0, 1'b0);
    drain();
    step(1'b1, 8'hF0, 1'b0, 1'b0);
    step(1'b1, 8'h1C, 1'b0, 1'b0);
    repeat (2) step(1'b0, 8'h00, 1'b0, 1'b0);
    drain();
    for (int ph = 0; ph < 4; ph++)
      for (int i = 0; i < 400; i++)
        step($urandom_range(0, 99) < ((ph % 2) != 0 ? 30 : 80),
             ($urandom_range(0, 7) == 0) ? 8'hF0 : 8'($urandom),
             $urandom_range(0, 99) < ((ph % 2) != 0 ? 70 : 20),
             $urandom_range(0, 15) == 0);
    repeat (2) step(1'b0, 8'h00, 1'b0, 1'b0);
    drain();
    repeat (2) step(1'b0, 8'h00, 1'b0, 1'b0);
    @(negedge clock_25);
    #1;
    chk("pending_pops", 32'(exp_q.size()), 0);
    chk("pending_status", 32'(st_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
